frame_loader_fsm: RTL and testbench

Write-side sequencer for the double-buffered frame memory. It streams one frame of packed pixel words from the upstream source, such as the SD/flash reader, into whichever bank the VGA side is not reading. It re-targets to the other bank on every mode switch and flags frames that were not fully loaded before the switch. It is started by the mode FSM's start_data_FSM pulse and paced by its switch_mode pulse.

---
 rtl/frame_loader_if.sv | 21 ++
 rtl/frame_loader_fsm.sv | 98 +++++++++
 tb/tb_frame_loader_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/frame_loader_if.sv
// frame_loader_if: source stream handshake and bank write port of the frame loader
interface frame_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              wr_en_b1;
    logic              wr_en_b2;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    modport master (
        input  src_data, src_valid,
        output src_ready, wr_en_b1, wr_en_b2, wr_addr, wr_data
    );
    modport slave (
        output src_data, src_valid,
        input  src_ready, wr_en_b1, wr_en_b2, wr_addr, wr_data
    );
endinterface

// File: rtl/frame_loader_fsm.sv
// frame_loader_fsm: streams source words into the frame bank not being read by VGA
module frame_loader_fsm #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 15,
    parameter int FRAME_WORDS  = 30000,
    parameter int TOTAL_FRAMES = 6572,
    parameter int FRAME_W      = 13
) (
    input  logic               CLK_40,
    input  logic               reset,
    input  logic               start,
    input  logic               switch_mode,
    input  logic               read_bank1,
    frame_loader_if.master     bus,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               busy,
    output logic               underrun,
    output logic [7:0]         underrun_count,
    output logic               video_done
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWITCH, DONE} state_t;
    state_t state, state_nxt;
    logic              tgt;
    logic [ADDR_W-1:0] addr;
    logic              wr_b1_q, wr_b2_q;
    logic              xfer, last_word, last_frame, active, restart, sw, ur;
    assign xfer       = bus.src_valid && bus.src_ready;
    assign last_word  = addr == ADDR_W'(FRAME_WORDS - 1);
    assign last_frame = frame_idx == FRAME_W'(TOTAL_FRAMES - 1);
    assign active     = state == LOAD || state == WAIT_SWITCH;
    assign restart    = start && (state == IDLE || state == DONE);
    assign sw         = switch_mode && active;
    // a switch abandons the frame unless its last word lands in the same cycle
    assign ur         = sw && state == LOAD && !(xfer && last_word);
    // a strobe registered just before reset must not reach the bank during reset
    assign bus.wr_en_b1 = wr_b1_q && !reset;
    assign bus.wr_en_b2 = wr_b2_q && !reset;

    // state register
    always_ff @(posedge CLK_40) begin
        state <= reset ? IDLE : state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = restart ? LOAD :
                    sw ? (last_frame ? DONE : LOAD) :
                    (state == LOAD && xfer && last_word) ? WAIT_SWITCH : state;
    end

    // state-decoded outputs
    always_comb begin
        bus.src_ready = state == LOAD;
        busy          = active;
        video_done    = state == DONE;
    end

    // write port, address/frame counters and target bank
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            wr_b1_q        <= 1'b0;
            wr_b2_q        <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            addr           <= '0;
            frame_idx      <= '0;
            tgt            <= 1'b0;
        end else begin
            wr_b1_q  <= xfer && !tgt;
            wr_b2_q  <= xfer && tgt;
            underrun <= ur;
            if (xfer) begin
                bus.wr_addr <= addr;
                bus.wr_data <= bus.src_data;
            end
            if (restart) begin
                addr           <= '0;
                frame_idx      <= '0;
                underrun_count <= '0;
                tgt            <= read_bank1;
            end else begin
                if (ur && underrun_count != 8'hFF)
                    underrun_count <= underrun_count + 1'b1;
                if (sw) begin
                    tgt <= !tgt;
                    if (!last_frame) begin
                        frame_idx <= frame_idx + 1'b1;
                        addr      <= '0;
                    end
                end else if (xfer && !last_word) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_loader_fsm.sv
// tb_frame_loader_fsm: scoreboard bench for frame_loader_fsm with 4-word frames, 3 frames
module tb_frame_loader_fsm;
    typedef struct packed {
        logic        b2;
        logic [14:0] a;
        logic [15:0] d;
    } wr_t;

    logic        CLK_40 = 1'b0;
    logic        reset, start, switch_mode, read_bank1;
    logic [12:0] frame_idx;
    logic        busy, underrun, video_done;
    logic [7:0]  underrun_count;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    wr_t         wq[$];

    frame_loader_if #(.DATA_W(16), .ADDR_W(15)) bus ();

    frame_loader_fsm #(
        .DATA_W(16), .ADDR_W(15), .FRAME_WORDS(4), .TOTAL_FRAMES(3), .FRAME_W(13)
    ) dut (
        .CLK_40(CLK_40), .reset(reset), .start(start), .switch_mode(switch_mode),
        .read_bank1(read_bank1), .bus(bus), .frame_idx(frame_idx), .busy(busy),
        .underrun(underrun), .underrun_count(underrun_count), .video_done(video_done)
    );

    always #5 CLK_40 = ~CLK_40;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK_40);
        #1;
    endtask

    task automatic word(input logic b2, input int a, input logic [15:0] d);
        bus.src_valid = 1'b1;
        bus.src_data  = d;
        wq.push_back('{b2: b2, a: 15'(a), d: d});
        cyc();
        bus.src_valid = 1'b0;
    endtask

    task automatic pulse_switch();
        switch_mode = 1'b1;
        cyc();
        switch_mode = 1'b0;
    endtask

    task automatic pulse_start(input logic rb1);
        read_bank1 = rb1;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // write monitor: every strobe must match the next expected write
    always @(negedge CLK_40) begin
        if (bus.wr_en_b1 || bus.wr_en_b2) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {bus.wr_en_b1, bus.wr_en_b2, bus.wr_addr[13:0], bus.wr_data}, 32'h0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_bank", {30'd0, bus.wr_en_b1, bus.wr_en_b2}, e.b2 ? 32'd1 : 32'd2);
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
    end

    logic [6:0]  pat = 7'b1011001;
    logic [14:0] pa;

    initial begin
        reset = 1'b1; start = 1'b0; switch_mode = 1'b0; read_bank1 = 1'b0;
        bus.src_valid = 1'b0; bus.src_data = '0;
        repeat (2) cyc();
        chk("rst_ready", 32'(bus.src_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr", {bus.wr_en_b1, bus.wr_en_b2, bus.wr_addr, bus.wr_data}, 0);
        chk("rst_status", {video_done, underrun, underrun_count, frame_idx}, 0);
        reset = 1'b0;
        pulse_switch();
        chk("idle_switch_ignored", {busy, bus.src_ready}, 0);

        pulse_start(1'b1);
        chk("load_ready", 32'(bus.src_ready), 1);
        chk("load_busy", 32'(busy), 1);
        chk("load_frame0", 32'(frame_idx), 0);
        for (int i = 0; i < 4; i++) word(1'b1, i, 16'hA0 + 16'(i));
        chk("wait_ready", 32'(bus.src_ready), 0);
        chk("wait_busy", 32'(busy), 1);

        read_bank1 = 1'b0;
        pulse_switch();
        chk("sw1_frame", 32'(frame_idx), 1);
        chk("sw1_ready", 32'(bus.src_ready), 1);
        for (int i = 0; i < 3; i++) word(1'b0, i, 16'hC0 + 16'(i));
        bus.src_valid = 1'b1; bus.src_data = 16'hC3; switch_mode = 1'b1;
        wq.push_back('{b2: 1'b0, a: 15'd3, d: 16'hC3});
        cyc();
        bus.src_valid = 1'b0; switch_mode = 1'b0;
        chk("coinc_frame", 32'(frame_idx), 2);
        chk("coinc_no_underrun", {underrun, underrun_count}, 0);
        chk("coinc_ready", 32'(bus.src_ready), 1);

        word(1'b1, 0, 16'hD0);
        word(1'b1, 1, 16'hD1);
        pulse_switch();
        chk("last_ur_pulse", 32'(underrun), 1);
        chk("last_ur_count", 32'(underrun_count), 1);
        chk("last_ur_done", {video_done, busy, bus.src_ready}, 32'h4);
        chk("last_ur_frame", 32'(frame_idx), 2);
        cyc();
        chk("ur_one_cycle", 32'(underrun), 0);
        pulse_switch();
        chk("done_switch_ignored", {video_done, frame_idx}, {1'b1, 13'd2});

        pulse_start(1'b0);
        chk("restart_done_drop", 32'(video_done), 0);
        chk("restart_frame", 32'(frame_idx), 0);
        chk("restart_count", 32'(underrun_count), 0);
        chk("restart_ready", 32'(bus.src_ready), 1);
        pulse_start(1'b1);
        chk("start_in_load_ignored", {busy, frame_idx}, {1'b1, 13'd0});

        pa = '0;
        for (int j = 0; j < 7; j++) begin
            bus.src_valid = pat[6-j];
            bus.src_data = 16'hE0 + 16'(j);
            if (pat[6-j]) begin
                wq.push_back('{b2: 1'b0, a: pa, d: 16'hE0 + 16'(j)});
                pa++;
            end
            cyc();
        end
        bus.src_valid = 1'b0;
        chk("gaps_wait_ready", 32'(bus.src_ready), 0);

        pulse_switch();
        chk("sw_gaps_frame", 32'(frame_idx), 1);
        word(1'b1, 0, 16'hF0);
        word(1'b1, 1, 16'hF1);
        pulse_switch();
        chk("ur_pulse", 32'(underrun), 1);
        chk("ur_count", 32'(underrun_count), 1);
        chk("ur_frame", 32'(frame_idx), 2);
        chk("ur_ready", 32'(bus.src_ready), 1);
        for (int i = 0; i < 4; i++) word(1'b0, i, 16'h50 + 16'(i));
        chk("f2_wait_ready", 32'(bus.src_ready), 0);
        pulse_switch();
        chk("done_flag", {video_done, busy, bus.src_ready}, 32'h4);
        chk("done_no_underrun", {underrun, underrun_count}, 32'h1);

        pulse_start(1'b1);
        word(1'b1, 0, 16'h70);
        bus.src_valid = 1'b1; bus.src_data = 16'h71;
        cyc();
        reset = 1'b1; bus.src_data = 16'h72;
        cyc();
        chk("midrst_wr", {bus.wr_en_b1, bus.wr_en_b2, bus.wr_addr, bus.wr_data}, 0);
        chk("midrst_status", {busy, bus.src_ready, video_done, underrun, underrun_count, frame_idx}, 0);
        reset = 1'b0; bus.src_valid = 1'b0;
        repeat (3) cyc();
        chk("post_rst_idle", {busy, bus.src_ready}, 0);
        chk("scoreboard_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
